// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared interrupt constants and types
// Purpose: line count, id width, conditioner timing defaults and the
// request/id/mode types shared by the conditioner, the controller and benches.
package irq_pkg;

  localparam int NUM_IRQ       = 8;
  localparam int IRQ_ID_W      = $clog2(NUM_IRQ);
  localparam int SYNC_STAGES   = 2;
  localparam int FILTER_CYCLES = 3;

  typedef logic [NUM_IRQ-1:0]  irq_vec_t;
  typedef logic [IRQ_ID_W-1:0] irq_id_t;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

  // True when the controller acknowledges exactly this line.
  function automatic logic ack_hit(input logic valid, input irq_id_t id, input int line);
    return valid && (int'(id) == line);
  endfunction

endpackage

// File: rtl/irq_line_filter.sv
// rtl/irq_line_filter.sv - per-line synchroniser, glitch filter and rise detect
// Purpose: conditions one already-normalised raw line.
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_active_raw    asynchronous line, 1 = active
//   o_filtered      filtered active level
//   o_rise          one-cycle pulse on a filtered 0->1 transition
module irq_line_filter
  import irq_pkg::*;
#(
  parameter int SYNC_DEPTH  = SYNC_STAGES,
  parameter int FILT_CYCLES = FILTER_CYCLES
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_active_raw,
  output logic o_filtered,
  output logic o_rise
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_DEPTH-1:0] r_sync;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_filtered;
  logic                  r_filtered_d;
  logic                  w_sync_out;

  assign w_sync_out = r_sync[SYNC_DEPTH-1];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync       <= '0;
      r_cnt        <= '0;
      r_filtered   <= 1'b0;
      r_filtered_d <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_DEPTH-2:0], i_active_raw};
      r_filtered_d <= r_filtered;
      if (w_sync_out == r_filtered) begin
        r_cnt <= '0;
      end else if (r_cnt >= CNT_LAST) begin
        // This edge is the FILT_CYCLES-th consecutive disagreement.
        r_filtered <= w_sync_out;
        r_cnt      <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filtered = r_filtered;
  assign o_rise     = r_filtered & ~r_filtered_d;

endmodule

// File: rtl/irq_input_conditioner.sv
// rtl/irq_input_conditioner.sv - interrupt source conditioning front end
// Purpose: normalises, synchronises and filters each raw interrupt line and
// presents level or sticky-edge requests to the interrupt controller.
// Ports:
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   i_irq_raw         asynchronous raw sources
//   i_polarity        1 = active-high source, 0 = active-low
//   i_edge_mode       1 = rising-edge capture, 0 = level pass-through
//   i_enable          per-line enable
//   i_ack_valid       one-cycle acknowledge strobe
//   i_ack_id          index of the acknowledged line
//   o_irq_requests    registered conditioned requests
//   o_overflow        sticky: edge arrived while the line was already latched
module irq_input_conditioner
  import irq_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NUM_IRQ-1:0]  i_irq_raw,
  input  logic [NUM_IRQ-1:0]  i_polarity,
  input  logic [NUM_IRQ-1:0]  i_edge_mode,
  input  logic [NUM_IRQ-1:0]  i_enable,
  input  logic                i_ack_valid,
  input  logic [IRQ_ID_W-1:0] i_ack_id,
  output logic [NUM_IRQ-1:0]  o_irq_requests,
  output logic [NUM_IRQ-1:0]  o_overflow
);

  irq_vec_t w_active_raw;
  irq_vec_t w_filtered;
  irq_vec_t w_rise;
  irq_vec_t w_req_nxt;
  irq_vec_t w_ovf_nxt;
  irq_vec_t r_requests;
  irq_vec_t r_overflow;
  irq_vec_t r_mode_d;

  // XNOR maps both polarities onto 1 = active.
  assign w_active_raw = ~(i_irq_raw ^ i_polarity);

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_line_filter u_filter (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_active_raw (w_active_raw[g]),
      .o_filtered   (w_filtered[g]),
      .o_rise       (w_rise[g])
    );
  end

  always_comb begin
    w_req_nxt = r_requests;
    w_ovf_nxt = r_overflow;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (i_edge_mode[i] != r_mode_d[i]) begin
        // A mode switch discards whatever the old mode had captured.
        w_req_nxt[i] = 1'b0;
        w_ovf_nxt[i] = 1'b0;
      end else if (irq_mode_e'(i_edge_mode[i]) == IRQ_LEVEL) begin
        w_req_nxt[i] = w_filtered[i] & i_enable[i];
        w_ovf_nxt[i] = 1'b0;
      end else if (!i_enable[i]) begin
        w_req_nxt[i] = 1'b0;
        w_ovf_nxt[i] = 1'b0;
      end else if (w_rise[i]) begin
        // A new edge beats a same-cycle ack; it only overflows when the
        // earlier request is still outstanding after this cycle.
        w_req_nxt[i] = 1'b1;
        if (r_requests[i] && !ack_hit(i_ack_valid, i_ack_id, i)) begin
          w_ovf_nxt[i] = 1'b1;
        end
      end else if (ack_hit(i_ack_valid, i_ack_id, i)) begin
        w_req_nxt[i] = 1'b0;
        w_ovf_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_requests <= '0;
      r_overflow <= '0;
      r_mode_d   <= '0;
    end else begin
      r_requests <= w_req_nxt;
      r_overflow <= w_ovf_nxt;
      r_mode_d   <= i_edge_mode;
    end
  end

  assign o_irq_requests = r_requests;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_irq_input_conditioner.sv
// tb/tb_irq_input_conditioner.sv - directed vector bench for irq_input_conditioner
module tb_irq_input_conditioner;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] pol;
    logic [7:0] edg;
    logic [7:0] en;
    logic       ackv;
    logic [2:0] ackid;
    int         n;
    logic [7:0] exp_req;
    logic [7:0] exp_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] irq_raw;
  logic [7:0] polarity;
  logic [7:0] edge_mode;
  logic [7:0] enable;
  logic       ack_valid;
  logic [2:0] ack_id;
  logic [7:0] irq_requests;
  logic [7:0] overflow;

  int n_pass  = 0;
  int n_total = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  irq_input_conditioner dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_irq_raw      (irq_raw),
    .i_polarity     (polarity),
    .i_edge_mode    (edge_mode),
    .i_enable       (enable),
    .i_ack_valid    (ack_valid),
    .i_ack_id       (ack_id),
    .o_irq_requests (irq_requests),
    .o_overflow     (overflow)
  );

  function automatic vec_t mk(input logic [7:0] raw, input logic [7:0] pol,
                              input logic [7:0] edg, input logic [7:0] en,
                              input logic ackv, input logic [2:0] ackid, input int n,
                              input logic [7:0] exp_req, input logic [7:0] exp_ovf);
    vec_t v;
    v.raw = raw; v.pol = pol; v.edg = edg; v.en = en;
    v.ackv = ackv; v.ackid = ackid; v.n = n;
    v.exp_req = exp_req; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [7:0] raw, input logic [7:0] pol, input logic [7:0] edg,
                       input logic [7:0] en, input logic ackv, input logic [2:0] ackid);
    irq_raw = raw; polarity = pol; edge_mode = edg; enable = en;
    ack_valid = ackv; ack_id = ackid;
  endtask

  initial begin
    // Level line 3, exact 5-edge latency both directions.
    tbl.push_back(mk(8'h08, 8'hFF, 8'h00, 8'hFF, 0, 0, 5, 8'h00, 8'h00));
    tbl.push_back(mk(8'h08, 8'hFF, 8'h00, 8'hFF, 0, 0, 1, 8'h08, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 0, 5, 8'h08, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 0, 1, 8'h00, 8'h00));
    // Glitch rejection line 5: 2-cycle pulse dropped, 3-cycle pulse passes.
    tbl.push_back(mk(8'h20, 8'hFF, 8'h00, 8'hFF, 0, 0, 2, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 0, 6, 8'h00, 8'h00));
    tbl.push_back(mk(8'h20, 8'hFF, 8'h00, 8'hFF, 0, 0, 3, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 0, 2, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 0, 1, 8'h20, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 0, 2, 8'h20, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 0, 1, 8'h00, 8'h00));
    // Edge line 2: latch, hold after raw drops, foreign ack ignored, ack clears.
    tbl.push_back(mk(8'h04, 8'hFF, 8'h04, 8'hFF, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h04, 8'hFF, 0, 0, 1, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h04, 8'hFF, 0, 0, 1, 8'h04, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h04, 8'hFF, 0, 0, 10, 8'h04, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h04, 8'hFF, 1, 6, 1, 8'h04, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h04, 8'hFF, 1, 2, 1, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h04, 8'hFF, 1, 2, 1, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h04, 8'hFF, 0, 0, 1, 8'h00, 8'h00));
    // Overflow on edge line 1, then ack clears both.
    tbl.push_back(mk(8'h02, 8'hFF, 8'h06, 8'hFF, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 1, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 1, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 6, 8'h02, 8'h00));
    tbl.push_back(mk(8'h02, 8'hFF, 8'h06, 8'hFF, 0, 0, 4, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 1, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 1, 8'h02, 8'h02));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 6, 8'h02, 8'h02));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 1, 1, 1, 8'h00, 8'h00));
    // Rise coincident with ack: request kept, no overflow.
    tbl.push_back(mk(8'h02, 8'hFF, 8'h06, 8'hFF, 0, 0, 4, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 2, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 6, 8'h02, 8'h00));
    tbl.push_back(mk(8'h02, 8'hFF, 8'h06, 8'hFF, 0, 0, 4, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 1, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 1, 1, 1, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 0, 0, 6, 8'h02, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h06, 8'hFF, 1, 1, 1, 8'h00, 8'h00));
    // Active-low line 0, enable gating.
    tbl.push_back(mk(8'h01, 8'hFE, 8'h06, 8'hFF, 0, 0, 6, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFE, 8'h06, 8'hFF, 0, 0, 5, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFE, 8'h06, 8'hFF, 0, 0, 1, 8'h01, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFE, 8'h06, 8'hFE, 0, 0, 1, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFE, 8'h06, 8'hFF, 0, 0, 1, 8'h01, 8'h00));

    rstn = 1'b0;
    drive(8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", irq_requests, 8'h00);
    check("reset_ovf", overflow, 8'h00);
    rstn = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].raw, tbl[r].pol, tbl[r].edg, tbl[r].en, tbl[r].ackv, tbl[r].ackid);
      repeat (tbl[r].n) step();
      check($sformatf("row%0d_req", r), irq_requests, tbl[r].exp_req);
      check($sformatf("row%0d_ovf", r), overflow, tbl[r].exp_ovf);
    end

    // All lines edge mode; line 0 is already filtered high so it never rises.
    drive(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 3'd0);
    repeat (5) step();
    check("alledge_pre", irq_requests, 8'h00);
    step();
    check("alledge_rise", irq_requests, 8'hFE);
    check("alledge_ovf", overflow, 8'h00);

    // Asynchronous reset mid-cycle clears outputs immediately.
    #2 rstn = 1'b0;
    #1;
    check("async_rst_req", irq_requests, 8'h00);
    check("async_rst_ovf", overflow, 8'h00);
    step();
    step();
    rstn = 1'b1;
    repeat (5) step();
    check("post_rst_pre", irq_requests, 8'h00);
    step();
    check("post_rst_rise", irq_requests, 8'hFF);
    check("post_rst_ovf", overflow, 8'h00);

    // Switching to level mode clears for one edge, then follows filtered.
    edge_mode = 8'h00;
    step();
    check("mode_sw_clear", irq_requests, 8'h00);
    step();
    check("mode_sw_level", irq_requests, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
